mem_responder: RTL and testbench

Memory-side responder for the multicycle RISC-V core's shared instruction/data port. Accepts one request at a time from the core's memory interface, inserts a fixed number of wait states, then completes the access with a one-cycle `ready` pulse and registered read data. Stands in for a slow unified memory so the core's stall logic is exercised. Holds a word-addressed array with per-byte write enables.

---
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port memory stand-in that answers each core access after WAIT_CYCLES wait states.
// Optional range checking of the latched address is enabled with MEM_RESP_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for req; latches the request when it arrives
// WAIT  | counting down the wait states
// RESP  | ready pulse; a pending write commits on the edge leaving this state
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] rd_addr;
    logic        rd_we;
    logic [31:0] rd_word;
    logic        rd_oor;
    logic        wr_oor;
    logic        enter_resp;
    logic        unused_bits;

    // With zero wait states RESP is entered on the accepting edge, so the
    // read must look at the live request rather than the request registers.
    assign rd_addr    = (state == IDLE) ? addr : addr_q;
    assign rd_we      = (state == IDLE) ? we : we_q;
    assign rd_word    = mem[rd_addr[AW+1:2]];
    assign enter_resp = (state_nxt == RESP);

`ifdef MEM_RESP_RANGE_CHECK_EN
    assign rd_oor = |rd_addr[31:AW+2];
    assign wr_oor = |addr_q[31:AW+2];
`else
    assign rd_oor = 1'b0;
    assign wr_oor = 1'b0;
`endif

    assign unused_bits = ^{addr[1:0], addr_q[1:0], addr[31:AW+2], addr_q[31:AW+2]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            ready   <= 1'b0;
            rdata   <= 32'd0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= enter_resp;
            err   <= enter_resp && rd_oor;
            if (state == IDLE && req) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
                cnt     <= WAIT_CYCLES[3:0];
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp && !rd_we) begin
                rdata <= rd_oor ? 32'd0 : rd_word;
            end
        end
    end

    // Array is not reset; state is forced to IDLE by reset, which discards pending writes.
    always_ff @(posedge clk) begin
        if (state == RESP && we_q && !wr_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[addr_q[AW+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed cases plus randomized accesses
// compared against a word-array reference model.
module tb_mem_responder;
    localparam int DEPTH = 1024;
    localparam int W     = 2;
`ifdef MEM_RESP_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  be = 4'd0;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_rd = 32'd0;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .ready(ready), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit out_of_range(input logic [31:0] a);
        return RC && (a >= 32'(DEPTH * 4));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    // Update the model for a completed access; returns expected err.
    function automatic bit model_access(input logic w, input logic [31:0] a,
                                        input logic [31:0] d, input logic [3:0] b);
        bit oor = out_of_range(a);
        if (!w) begin
            last_rd = oor ? 32'd0 : ref_mem[widx(a)];
        end else if (!oor) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) ref_mem[widx(a)][8*i +: 8] = d[8*i +: 8];
        end
        return oor;
    endfunction

    // Called at a negedge while the DUT is idle.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b);
        int k = 0;
        bit exp_err;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        do begin
            @(negedge clk);
            k++;
        end while (!ready && k < 40);
        req = 1'b0;
        check("latency", 32'(k), 32'(1 + W));
        exp_err = model_access(w, a, d, b);
        check(w ? "wr_rdata_held" : "rd_data", rdata, last_rd);
        check("err", {31'd0, err}, {31'd0, exp_err});
        @(negedge clk);
        check("ready_single", {31'd0, ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  b;
        logic        w;
        int          k;

        // reset while idle
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // full word write then read
        access(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
        access(1'b0, 32'h10, 32'h0, 4'b0000);
        check("wr_rd_word", rdata, 32'hDEADBEEF);

        // byte enables
        access(1'b1, 32'h20, 32'h11223344, 4'b1111);
        access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        access(1'b0, 32'h20, 32'h0, 4'b0000);
        check("be_merge", rdata, 32'h11BB33DD);

        // be=0000 write changes nothing
        access(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
        access(1'b0, 32'h22, 32'h0, 4'b0000);
        check("be_none", rdata, 32'h11BB33DD);

        // back-to-back reads with req held high
        access(1'b1, 32'h14, 32'h01020304, 4'b1111);
        access(1'b1, 32'h18, 32'h05060708, 4'b1111);
        access(1'b1, 32'h1C, 32'h090A0B0C, 4'b1111);
        req = 1'b1; we = 1'b0; addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!ready && k < 40);
            check("b2b_period", 32'(k), (i == 0) ? 32'(1 + W) : 32'(2 + W));
            check("b2b_rdata", rdata, ref_mem[widx(32'h10 + 32'(4 * i))]);
            if (i < 3) addr = 32'h10 + 32'(4 * (i + 1));
            else req = 1'b0;
        end
        last_rd = ref_mem[widx(32'h1C)];
        @(negedge clk);

        // reset during WAIT of a write
        access(1'b1, 32'h30, 32'h0, 4'b1111);
        req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; be = 4'b1111;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
        k = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready) k++;
        end
        check("rst_mid_noready", 32'(k), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        rst = 1'b1;
        last_rd = 32'd0;
        @(negedge clk);
        access(1'b0, 32'h30, 32'h0, 4'b0000);
        check("rst_mid_discard", rdata, 32'd0);

        // address range
        access(1'b1, 32'h0, 32'h5A5AA5A5, 4'b1111);
        access(1'b0, 32'h1000, 32'h0, 4'b0000);
        check("range_rdata", rdata, RC ? 32'd0 : 32'h5A5AA5A5);
        access(1'b1, 32'h1000, 32'h12345678, 4'b1111);
        access(1'b0, 32'h0, 32'h0, 4'b0000);
        check("range_write", rdata, RC ? 32'h5A5AA5A5 : 32'h12345678);

        // randomized accesses over 16 words, with aliases and ignored low bits
        for (int i = 0; i < 16; i++)
            access(1'b1, 32'(4 * i), $urandom, 4'b1111);
        for (int i = 0; i < 60; i++) begin
            a = 32'(4 * $urandom_range(0, 15)) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 7) * DEPTH * 4);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            access(w, a, d, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end expected end of test");
        $fatal(1);
    end

endmodule
